// File: rtl/sdr_pkg.sv
// Shared types and constants for the toggle req/ack SDRAM port responder.
package sdr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } sdr_state_e;

    localparam logic       PORT1  = 1'b0;
    localparam logic       PORT2  = 1'b1;
    localparam logic [1:0] RD_SEL = 2'b00;

endpackage

// File: rtl/sdr_rr_arbiter.sv
// Two-port arbiter: fixed port 1 priority, or alternate on contention using a
// preferred-port register that is updated when a transaction completes.
module sdr_rr_arbiter
    import sdr_pkg::*;
#(
    parameter int unsigned ROUND_ROBIN = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pend1_i,
    input  logic pend2_i,
    input  logic update_i,
    input  logic served_i,
    output logic gnt_valid_o,
    output logic gnt_o
);

    // Port that wins the next contention; the opposite of the last port served.
    logic prio_q, prio_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prio_q <= PORT1;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (update_i) begin
            prio_d = ~served_i;
        end
    end

    always_comb begin
        gnt_valid_o = pend1_i | pend2_i;
        if (pend1_i && pend2_i) begin
            gnt_o = (ROUND_ROBIN != 0) ? prio_q : PORT1;
        end else if (pend1_i) begin
            gnt_o = PORT1;
        end else begin
            gnt_o = PORT2;
        end
    end

endmodule

// File: rtl/sdr_port_responder.sv
// Responder for two toggle req/ack client ports sharing one SDRAM command
// interface; all outputs are registered.
module sdr_port_responder
    import sdr_pkg::*;
#(
    parameter int unsigned AW          = 24,
    parameter int unsigned ROUND_ROBIN = 1
) (
    input  logic          CLK_32M,
    input  logic          reset,
    input  logic [AW:1]   p1_addr,
    input  logic [15:0]   p1_din,
    input  logic [1:0]    p1_wr_sel,
    input  logic          p1_req,
    output logic          p1_ack,
    output logic [15:0]   p1_dout,
    input  logic [AW:1]   p2_addr,
    input  logic [15:0]   p2_din,
    input  logic [1:0]    p2_wr_sel,
    input  logic          p2_req,
    output logic          p2_ack,
    output logic [15:0]   p2_dout,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW:1]   mem_addr,
    output logic [15:0]   mem_din,
    output logic [1:0]    mem_be,
    output logic          mem_we,
    input  logic          mem_rvalid,
    input  logic [15:0]   mem_rdata,
    output logic          busy
);

    sdr_state_e  state_q, state_d;
    logic        port_q, port_d;
    logic        mem_valid_q, mem_valid_d;
    logic [AW:1] mem_addr_q, mem_addr_d;
    logic [15:0] mem_din_q, mem_din_d;
    logic [1:0]  mem_be_q, mem_be_d;
    logic        mem_we_q, mem_we_d;
    logic        p1_ack_q, p1_ack_d, p2_ack_q, p2_ack_d;
    logic [15:0] p1_dout_q, p1_dout_d, p2_dout_q, p2_dout_d;
    logic        busy_q, busy_d;

    logic p1_pend, p2_pend, gnt_valid, gnt_port, accept, done;

    assign p1_pend = p1_req != p1_ack_q;
    assign p2_pend = p2_req != p2_ack_q;
    assign accept  = mem_valid_q & mem_ready;
    assign done    = ((state_q == ISSUE) && accept && mem_we_q) ||
                     ((state_q == RDWAIT) && mem_rvalid);

    sdr_rr_arbiter #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_arb (
        .clk_i       (CLK_32M),
        .rst_i       (reset),
        .pend1_i     (p1_pend),
        .pend2_i     (p2_pend),
        .update_i    (done),
        .served_i    (port_q),
        .gnt_valid_o (gnt_valid),
        .gnt_o       (gnt_port)
    );

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (gnt_valid) state_d = ISSUE;
            ISSUE:   if (accept) state_d = mem_we_q ? IDLE : RDWAIT;
            RDWAIT:  if (mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        port_d      = port_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_be_d    = mem_be_q;
        mem_we_d    = mem_we_q;
        p1_ack_d    = p1_ack_q;
        p2_ack_d    = p2_ack_q;
        p1_dout_d   = p1_dout_q;
        p2_dout_d   = p2_dout_q;
        busy_d      = state_d != IDLE;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    port_d      = gnt_port;
                    mem_valid_d = 1'b1;
                    if (gnt_port == PORT2) begin
                        mem_addr_d = p2_addr;
                        mem_din_d  = p2_din;
                        mem_be_d   = p2_wr_sel;
                        mem_we_d   = p2_wr_sel != RD_SEL;
                    end else begin
                        mem_addr_d = p1_addr;
                        mem_din_d  = p1_din;
                        mem_be_d   = p1_wr_sel;
                        mem_we_d   = p1_wr_sel != RD_SEL;
                    end
                end
            end
            ISSUE: begin
                if (accept) begin
                    mem_valid_d = 1'b0;
                    // Writes complete at acceptance; reads wait for data.
                    if (mem_we_q) begin
                        if (port_q == PORT2) p2_ack_d = ~p2_ack_q;
                        else                 p1_ack_d = ~p1_ack_q;
                    end
                end
            end
            RDWAIT: begin
                if (mem_rvalid) begin
                    if (port_q == PORT2) begin
                        p2_dout_d = mem_rdata;
                        p2_ack_d  = ~p2_ack_q;
                    end else begin
                        p1_dout_d = mem_rdata;
                        p1_ack_d  = ~p1_ack_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_32M or posedge reset) begin
        if (reset) begin
            port_q      <= PORT1;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_be_q    <= '0;
            mem_we_q    <= 1'b0;
            p1_ack_q    <= 1'b0;
            p2_ack_q    <= 1'b0;
            p1_dout_q   <= '0;
            p2_dout_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            port_q      <= port_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_be_q    <= mem_be_d;
            mem_we_q    <= mem_we_d;
            p1_ack_q    <= p1_ack_d;
            p2_ack_q    <= p2_ack_d;
            p1_dout_q   <= p1_dout_d;
            p2_dout_q   <= p2_dout_d;
            busy_q      <= busy_d;
        end
    end

    assign p1_ack    = p1_ack_q;
    assign p2_ack    = p2_ack_q;
    assign p1_dout   = p1_dout_q;
    assign p2_dout   = p2_dout_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_be    = mem_be_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;

endmodule

// File: doc/sdr_port_responder.md
Name: sdr_port_responder

Overview:
- Responder end of the toggle req/ack SDRAM port protocol used by the M72 core.
- Two client ports: port 1 is CPU ROM/RAM, port 2 is sprite DMA.
- Each client requests by making sdr_req differ from sdr_ack. The block arbitrates, issues one command to the SDRAM controller's command interface, returns read data, and completes the transaction by toggling ack so that ack equals req again.

Parameters:
- AW, 24, word-address width; address bits are [AW:1].
- ROUND_ROBIN, 1: 1 = alternate grants on contention; 0 = port 1 always wins.

Ports:
- CLK_32M  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- p1_addr  in  AW  port 1 word address [AW:1].
- p1_din  in  16  port 1 write data.
- p1_wr_sel  in  2  port 1 byte enables; 00 = read, nonzero = write of the selected bytes.
- p1_req  in  1  port 1 request toggle.
- p1_ack  out  1  port 1 acknowledge toggle.
- p1_dout  out  16  port 1 read data.
- p2_addr, p2_din, p2_wr_sel, p2_req, p2_ack, p2_dout: identical to port 1, for port 2.
- mem_valid  out  1  command valid to the SDRAM controller.
- mem_ready  in  1  controller accepts the command this cycle.
- mem_addr  out  AW  command word address.
- mem_din  out  16  write data.
- mem_be  out  2  byte enables; 00 on reads.
- mem_we  out  1  1 = write.
- mem_rvalid  in  1  read data valid (one cycle).
- mem_rdata  in  16  read data.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: asynchronous and active-high; clock is CLK_32M.
  - State goes to IDLE; p1_ack, p2_ack, mem_valid, mem_we, busy = 0; mem_addr, mem_din, mem_be, p1_dout, p2_dout = 0; round-robin pointer = port 1.
- Pending: pN_pend = (pN_req != pN_ack), evaluated combinationally.
  - A client whose req is 1 when reset is released is therefore pending.
- Clients must hold addr, din and wr_sel stable and must not toggle req while pending. The block samples these fields once, at grant.
- All outputs are registered.
- FSM states:
  - IDLE: if any port is pending, grant one.
    - Both pending: ROUND_ROBIN=1 grants the port not served last; ROUND_ROBIN=0 grants port 1.
    - On grant: latch addr/din/wr_sel into mem_addr/mem_din/mem_be; set mem_we = |wr_sel; set mem_valid = 1; go to ISSUE.
  - ISSUE: mem_valid held until mem_ready is seen high while mem_valid = 1.
    - On acceptance: mem_valid drops next cycle.
    - Write: toggle the granted ack in that same edge, then go to IDLE.
    - Read: go to RDWAIT.
  - RDWAIT: on mem_rvalid, load mem_rdata into the granted pN_dout and toggle pN_ack in the same edge, so data and ack update together. Then go to IDLE and update the round-robin pointer.
- Latency: req toggle at edge N.
  - mem_valid high after edge N+1.
  - With mem_ready tied high, write ack toggles after edge N+2.
  - Read ack toggles on the edge that samples mem_rvalid.
- A write never changes pN_dout. pN_dout holds its value until the next read completes on that port.
- mem_rvalid outside RDWAIT is ignored. mem_ready outside ISSUE is ignored.
- The ungranted port waits while pending. Its ack does not change until it is served.
- IDLE re-evaluates on the cycle after returning. Back-to-back service has one idle cycle between commands.
- Reset mid-transaction abandons the command: mem_valid drops immediately and no ack toggles. The controller must itself be reset alongside this block.

Decomposition:
- Shared package sdr_pkg: state encoding (IDLE, ISSUE, RDWAIT), the port index constants PORT1 and PORT2, and the RD_SEL = 2'b00 constant.
- One sub-module, sdr_rr_arbiter: two pend inputs, last-served register, grant output, and an update strobe driven on completion.
- Port datapath and FSM stay in the top module.

Test Plan:
- Port 1 read of addr 24'h000123, mem_ready high, mem_rvalid with 16'hBEEF two cycles after accept -> p1_dout = BEEF and p1_ack = p1_req on the same edge; p2_ack unchanged.
- Port 2 write, wr_sel = 2'b10, din = 16'h5A00, mem_ready delayed 3 cycles -> mem_valid held 4 cycles, mem_be = 10, mem_we = 1; p2_ack toggles on the edge after acceptance; p2_dout unchanged.
- Both ports toggle req in the same cycle with ROUND_ROBIN=1, repeated 4 times -> grants alternate 1,2,1,2. With ROUND_ROBIN=0, port 1 is served first in every pair.
- Stray mem_rvalid pulse in IDLE, and again in ISSUE -> no dout change and no ack toggle.
- reset asserted during RDWAIT -> mem_valid = 0 and acks = 0 immediately. After release with p1_req = 1, a fresh port 1 command issues.
- 100 random back-to-back requests against a model memory -> every ack toggles exactly once per req toggle, and read data matches the prior writes including byte enables.
